// File: rtl/lane_scheduler.sv
// Game-level sequencer for the car/log lanes: per-lane step pulses at level-dependent
// rates, the play/freeze/level-up/game-over FSM, lives and level bookkeeping.
module lane_scheduler #(
  parameter int NUM_LANES    = 8,
  parameter int PRESCALE_W   = 9,
  parameter int BASE_PERIOD  = 8,
  parameter int LANE_SKEW    = 1,
  parameter int LEVEL_STEP   = 1,
  parameter int MIN_PERIOD   = 2,
  parameter int MAX_LEVEL    = 7,
  parameter int LIVES        = 3,
  parameter int FREEZE_TICKS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 hit,
  input  logic                 frog_home,
  output logic [NUM_LANES-1:0] step,
  output logic                 lane_reset,
  output logic                 playing,
  output logic                 game_over,
  output logic [2:0]           level,
  output logic [1:0]           lives_left
);

  localparam int MAXP  = BASE_PERIOD + (NUM_LANES - 1) * LANE_SKEW;
  localparam int TOPP  = (MAXP > MIN_PERIOD) ? MAXP : MIN_PERIOD;
  localparam int CNT_W = (TOPP > 1) ? $clog2(TOPP) : 1;
  localparam int FRZ_W = (FREEZE_TICKS > 1) ? $clog2(FREEZE_TICKS) : 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_FREEZE = 3'd2,
    ST_LVLUP  = 3'd3,
    ST_OVER   = 3'd4
  } state_t;

  state_t                          state_q, state_d;
  logic [PRESCALE_W-1:0]           presc_q, presc_d;
  logic [NUM_LANES-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [FRZ_W-1:0]                frz_q, frz_d;
  logic [NUM_LANES-1:0]            step_q, step_d;
  logic                            lane_reset_q, lane_reset_d;
  logic                            playing_q, playing_d;
  logic                            game_over_q, game_over_d;
  logic [2:0]                      level_q, level_d;
  logic [1:0]                      lives_q, lives_d;
  logic                            tick_s;

  // Last count value of lane i at the given level; evaluated signed so the floor holds.
  function automatic logic [CNT_W-1:0] lane_last(input int lane, input logic [2:0] lvl);
    int p;
    p = BASE_PERIOD + lane * LANE_SKEW - int'(lvl) * LEVEL_STEP;
    if (p < MIN_PERIOD) begin
      p = MIN_PERIOD;
    end else begin
      p = p;
    end
    return CNT_W'(p - 1);
  endfunction

  assign tick_s = ((state_q == ST_RUN) || (state_q == ST_FREEZE)) && (presc_q == '1);

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      cnt_q        <= '0;
      frz_q        <= '0;
      step_q       <= '0;
      lane_reset_q <= 1'b0;
      playing_q    <= 1'b0;
      game_over_q  <= 1'b0;
      level_q      <= 3'd0;
      lives_q      <= 2'(LIVES);
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      frz_q        <= frz_d;
      step_q       <= step_d;
      lane_reset_q <= lane_reset_d;
      playing_q    <= playing_d;
      game_over_q  <= game_over_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
    end
  end

  // Next state, freeze tick count, level and lives.
  always_comb begin
    state_d = state_q;
    frz_d   = '0;
    level_d = level_q;
    lives_d = lives_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          lives_d = 2'(LIVES);
          level_d = 3'd0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (hit) begin
          state_d = ST_FREEZE;
          lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
        end else if (frog_home) begin
          state_d = ST_LVLUP;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FREEZE: begin
        if (tick_s && (frz_q == FRZ_W'(FREEZE_TICKS - 1))) begin
          state_d = (lives_q == 2'd0) ? ST_OVER : ST_RUN;
        end else if (tick_s) begin
          frz_d = frz_q + 1'b1;
        end else begin
          frz_d = frz_q;
        end
      end
      ST_LVLUP: begin
        level_d = (level_q == 3'(MAX_LEVEL)) ? level_q : level_q + 3'd1;
        state_d = ST_RUN;
      end
      ST_OVER: begin
        if (start) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_OVER;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs, prescaler and lane counters; every entry into RUN is a lane_reset.
  always_comb begin
    lane_reset_d = (state_d == ST_RUN) && (state_q != ST_RUN);
    playing_d    = (state_d == ST_RUN);
    game_over_d  = (state_d == ST_OVER);
    if (lane_reset_d) begin
      presc_d = '0;
    end else if ((state_q == ST_RUN) || (state_q == ST_FREEZE)) begin
      presc_d = presc_q + 1'b1;
    end else begin
      presc_d = presc_q;
    end
    cnt_d  = cnt_q;
    step_d = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (lane_reset_d) begin
        cnt_d[i] = '0;
      end else if ((state_q == ST_RUN) && tick_s) begin
        if (cnt_q[i] == lane_last(i, level_q)) begin
          cnt_d[i]  = '0;
          step_d[i] = (state_d == ST_RUN);
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  assign step       = step_q;
  assign lane_reset = lane_reset_q;
  assign playing    = playing_q;
  assign game_over  = game_over_q;
  assign level      = level_q;
  assign lives_left = lives_q;

endmodule

// File: tb/tb_lane_scheduler.sv
// Scoreboard bench for lane_scheduler (tick every 4 cycles): expected lane_reset and
// step[0]/step[7] pulse cycles are queued by the stimulus and popped by a monitor.
module tb_lane_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, hit, frog_home;
  logic [7:0] step;
  logic       lane_reset, playing, game_over;
  logic [2:0] level;
  logic [1:0] lives_left;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int cyc;
    int lvl;
    int lives;
  } lr_t;

  lr_t exp_lr[$];
  int  exp_s0[$];
  int  exp_s7[$];

  int p0_tab[8] = '{32, 28, 24, 20, 16, 12, 8, 8};
  int p7_tab[8] = '{60, 56, 52, 48, 44, 40, 36, 32};

  lane_scheduler #(.PRESCALE_W(2)) dut (
    .clk(clk), .reset(rst_n), .start(start), .hit(hit), .frog_home(frog_home),
    .step(step), .lane_reset(lane_reset), .playing(playing), .game_over(game_over),
    .level(level), .lives_left(lives_left)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: unexpected pulse at cycle %0d", name, cyc);
  endtask

  // Monitor: every observed pulse is matched against the head of its queue.
  always @(negedge clk) begin : monitor
    lr_t e;
    int  c;
    if (lane_reset) begin
      if (exp_lr.size() == 0) begin
        unexpected("lane_reset");
      end else begin
        e = exp_lr.pop_front();
        chk("lane_reset_cycle", cyc, e.cyc);
        chk("lane_reset_level", int'(level), e.lvl);
        chk("lane_reset_lives", int'(lives_left), e.lives);
      end
    end
    if (step[0]) begin
      if (exp_s0.size() == 0) begin
        unexpected("step0");
      end else begin
        c = exp_s0.pop_front();
        chk("step0_cycle", cyc, c);
      end
    end
    if (step[7]) begin
      if (exp_s7.size() == 0) begin
        unexpected("step7");
      end else begin
        c = exp_s7.pop_front();
        chk("step7_cycle", cyc, c);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic s, input logic h, input logic f);
    start = s; hit = h; frog_home = f;
    @(posedge clk);
    #1;
    start = 1'b0; hit = 1'b0; frog_home = 1'b0;
  endtask

  // Queue the step pulses due within dur cycles of lane_reset at l0, then wait there.
  task automatic run_lanes(input int l0, input int p0, input int p7, input int dur);
    for (int k = l0 + p0; k <= l0 + dur; k += p0) exp_s0.push_back(k);
    for (int k = l0 + p7; k <= l0 + dur; k += p7) exp_s7.push_back(k);
    wait_until(l0 + dur);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int c, l, lvl, bad;
    rst_n = 1'b0; start = 1'b0; hit = 1'b0; frog_home = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_step", int'(step), 0);
    chk("rst_lane_reset", int'(lane_reset), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_lives", int'(lives_left), 3);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Start: lane_reset next cycle, level-0 rates.
    c = cyc;
    exp_lr.push_back('{c + 1, 0, 3});
    pulse(1'b1, 1'b0, 1'b0);
    chk("start_playing", int'(playing), 1);
    l = c + 1;
    run_lanes(l, 32, 60, 131);

    // hit and frog_home together: freeze wins, level kept, 64-cycle freeze.
    c = cyc;
    exp_lr.push_back('{c + 65, 0, 2});
    pulse(1'b0, 1'b1, 1'b1);
    chk("both_lives", int'(lives_left), 2);
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      if (playing || (step != 8'd0)) bad++;
      if (i == 10) begin
        hit = 1'b1; frog_home = 1'b1;
      end else begin
        hit = 1'b0; frog_home = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    chk("freeze_busy_cycles", bad, 0);
    chk("freeze_resume_playing", int'(playing), 1);
    chk("freeze_ignored_hit_lives", int'(lives_left), 2);
    chk("both_level", int'(level), 0);
    l = c + 65;

    // Eight level-ups: level saturates at 7, lane 0 period clamps at 8 cycles.
    lvl = 0;
    for (int n = 1; n <= 8; n++) begin
      run_lanes(l, p0_tab[lvl], p7_tab[lvl], 70);
      c = cyc;
      lvl = (n > 7) ? 7 : n;
      exp_lr.push_back('{c + 2, lvl, 2});
      pulse(1'b0, 1'b0, 1'b1);
      chk("lvlup_playing", int'(playing), 0);
      l = c + 2;
      wait_until(l);
    end
    chk("level_saturated", int'(level), 7);

    // Second hit at level 7.
    run_lanes(l, 8, 32, 71);
    c = cyc;
    exp_lr.push_back('{c + 65, 7, 1});
    pulse(1'b0, 1'b1, 1'b0);
    chk("hit2_lives", int'(lives_left), 1);
    wait_until(c + 65);
    chk("hit2_playing", int'(playing), 1);
    l = c + 65;

    // Third hit: game over after the freeze, no lane_reset.
    run_lanes(l, 8, 32, 71);
    c = cyc;
    pulse(1'b0, 1'b1, 1'b0);
    chk("hit3_lives", int'(lives_left), 0);
    wait_until(c + 64);
    chk("hit3_still_frozen", int'(game_over), 0);
    wait_until(c + 65);
    chk("over_game_over", int'(game_over), 1);
    chk("over_playing", int'(playing), 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    pulse(1'b1, 1'b0, 1'b0);
    chk("idle_game_over", int'(game_over), 0);
    chk("idle_playing", int'(playing), 0);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("idle_holds", int'(playing), 0);
    c = cyc;
    exp_lr.push_back('{c + 1, 0, 3});
    pulse(1'b1, 1'b0, 1'b0);
    chk("restart_lives", int'(lives_left), 3);
    chk("restart_level", int'(level), 0);
    chk("restart_playing", int'(playing), 1);
    l = c + 1;

    // Async reset one cycle before step[0] is due.
    run_lanes(l, 32, 60, 63);
    rst_n = 1'b0;
    #1;
    chk("async_playing", int'(playing), 0);
    chk("async_step", int'(step), 0);
    chk("async_lives", int'(lives_left), 3);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("async_step_held", int'(step), 0);
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("post_reset_idle", int'(playing), 0);

    chk("pending_lane_reset", exp_lr.size(), 0);
    chk("pending_step0", exp_s0.size(), 0);
    chk("pending_step7", exp_s7.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
